sgb_lcd_row_capture: RTL
========================

Name: sgb_lcd_row_capture

Overview:
- Downstream consumer of the Game Boy core's LCD pixel stream (lcd_ce / lcd_data / lcd_vs) inside the SGB mapper.
- Packs 2bpp pixels into SNES planar tile format in a 4-entry ring of tile-row buffers. Each buffer holds 8 GB lines, i.e. 20 tiles × 16 bytes = 320 bytes.
- Exposes a byte-sequential read port for the ICD2 register file: row select on $6001, data on $7800.
- Reports the current GB line/row position for the status read at $6000.

Parameters:
- NUM_BUF, 4, number of ring row buffers (power of two).
- LINE_PIX, 160, visible pixels per GB line.
- FRAME_LINES, 144, visible lines per GB frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- lcd_ce  in  1  one-cycle pixel-valid strobe from GB core
- lcd_data  in  2  pixel colour index; bit0→plane0, bit1→plane1
- lcd_vs  in  1  GB vertical sync level
- rd_sel  in  2  buffer index to read
- rd_sel_wr  in  1  pulse: latch rd_sel, reset read pointer to 0
- rd_strobe  in  1  pulse: one SNES read of $7800 completed; advance pointer
- rd_data  out  8  byte at current read pointer of selected buffer
- cur_line  out  8  GB line currently being captured (0..143)
- cur_buf  out  2  buffer currently being written, = cur_line[4:3]
- row_done  out  1  one-cycle pulse when line 7 of a tile row is fully written

Behaviour:
- Reset values: all counters 0, shift regs 0, rd_data 8'h00, cur_line 0, cur_buf 0, row_done 0, rd_ptr 0, rd_buf 0. Buffer RAM contents are undefined and are not cleared.
- Vsync:
  - lcd_vs is synchronised with a 1-flop edge detector.
  - On a rising edge: pix_cnt←0, cur_line←0, shift regs cleared.
  - A vsync edge in mid-line discards the partial tile.
- Pixel capture (each lcd_ce while cur_line < FRAME_LINES):
  - p0 ← {p0[6:0], lcd_data[0]}, p1 ← {p1[6:0], lcd_data[1]}.
  - The first pixel of a tile therefore ends up in bit 7.
  - pix_cnt increments.
- Tile write:
  - Triggered when pix_cnt[2:0]==7 on the lcd_ce cycle.
  - Next cycle writes the 16-bit word {plane1, plane0} into RAM.
  - Word address = cur_buf*160 + (pix_cnt>>3)*8 + cur_line[2:0].
  - Byte order on readback: even byte = plane0, odd byte = plane1.
- Line end:
  - The cycle after the 160th pixel: pix_cnt←0, cur_line←cur_line+1.
  - If the old cur_line[2:0]==7, row_done pulses for one cycle concurrent with the increment.
- Overflow:
  - When cur_line reaches FRAME_LINES, lcd_ce is ignored until the next vsync.
  - cur_line holds at 144 in that state.
- Ring wrap: cur_buf = cur_line[4:3] (mod 4). Buffer 0 is reused at lines 32, 64, …
- Read pointer:
  - rd_sel_wr: rd_buf←rd_sel, rd_ptr←0.
  - rd_strobe: rd_ptr←rd_ptr+1, wrapping 319→0.
  - If rd_sel_wr and rd_strobe occur in the same cycle, rd_sel_wr wins and rd_ptr=0.
- Read data:
  - Word address = rd_buf*160 + rd_ptr[8:1]; byte = rd_ptr[0] ? hi : lo.
  - RAM is dual-port, with a registered read port and a registered output mux.
  - rd_data is valid 2 clk after any change of rd_ptr or rd_buf.
  - A read of the same address in the same cycle as a write returns the old data.
- Arithmetic: pix_cnt is 8 bits, rd_ptr is 9 bits, cur_line is 8 bits, RAM address is 10 bits (640 words).

Test Plan:
- Reset, then one full line of pixels with lcd_data = 2'b01 repeating 8× then 2'b10 8× → word 0 = 16'h00FF, word 8 = 16'hFF00. cur_line goes 0→1 after pixel 160; row_done stays 0.
- 8 lines of pixels, line n filled with colour 3 only on pixel n → row_done pulses exactly once after line 7. Buffer 0 word n = {8'h80>>n, 8'h80>>n} for tile 0; cur_buf becomes 1.
- 33 lines captured → cur_buf = 0 at line 32, and buffer 0 tile 0 row 0 is overwritten with line-32 data.
- rd_sel=2 with rd_sel_wr, then 321 rd_strobe pulses → bytes follow buffer 2 in order (lo, hi per word). The pointer wraps so that the 321st strobe leaves rd_ptr=1. rd_data is checked 2 clk after each strobe.
- lcd_vs rising edge at pixel 83 of line 5 → cur_line=0, pix_cnt=0. The next frame's first tile write goes to address 0, and no stale shift-register bits appear.
- 150 lines without vsync → cur_line holds at 144, no RAM writes after line 143. Then rst_n is asserted mid-line → all outputs return to reset values immediately.

Source files
------------

// File: rtl/sgb_lcd_row_capture.sv
// Captures the Game Boy LCD pixel stream into a ring of SNES-planar tile-row buffers
// and serves the buffered bytes sequentially to the ICD2 register file.
module sgb_lcd_row_capture #(
   parameter int unsigned NUM_BUF     = 4,
   parameter int unsigned LINE_PIX    = 160,
   parameter int unsigned FRAME_LINES = 144
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       lcd_ce,
   input  logic [1:0]                 lcd_data,
   input  logic                       lcd_vs,
   input  logic [$clog2(NUM_BUF)-1:0] rd_sel,
   input  logic                       rd_sel_wr,
   input  logic                       rd_strobe,
   output logic [7:0]                 rd_data,
   output logic [7:0]                 cur_line,
   output logic [$clog2(NUM_BUF)-1:0] cur_buf,
   output logic                       row_done
);

   localparam int unsigned BW        = $clog2(NUM_BUF);
   // One buffer = 8 lines x (LINE_PIX/8) tiles = LINE_PIX 16-bit words
   localparam int unsigned BUF_WORDS = LINE_PIX;
   localparam int unsigned DEPTH     = NUM_BUF * BUF_WORDS;
   localparam int unsigned AW        = $clog2(DEPTH);

   localparam logic [7:0] PIX_END   = 8'(LINE_PIX);
   localparam logic [7:0] LINE_END  = 8'(FRAME_LINES);
   localparam logic [8:0] PTR_LAST  = 9'(2 * BUF_WORDS - 1);
   localparam logic [AW-1:0] BUF_SZ = AW'(BUF_WORDS);

   logic          vs_q;
   logic          vs_rise;
   logic [7:0]    pix_cnt_q;
   logic [6:0]    p0_q, p1_q;
   logic [7:0]    p0_nxt, p1_nxt;
   logic          capture;
   logic          tile_done;
   logic          line_end;
   logic          wr_en_q;
   logic [AW-1:0] wr_addr_q;
   logic [15:0]   wr_data_q;
   logic [AW-1:0] tile_addr;

   logic [15:0]   mem [DEPTH];
   logic [15:0]   mem_q;
   logic [BW-1:0] rd_buf_q;
   logic [8:0]    rd_ptr_q;
   logic          hi_q;
   logic [AW-1:0] rd_addr;

   assign vs_rise   = lcd_vs & ~vs_q;
   assign line_end  = (pix_cnt_q == PIX_END);
   assign capture   = lcd_ce && (cur_line < LINE_END) && !line_end;
   assign tile_done = capture && (pix_cnt_q[2:0] == 3'd7);
   assign p0_nxt    = {p0_q, lcd_data[0]};
   assign p1_nxt    = {p1_q, lcd_data[1]};
   assign cur_buf   = cur_line[BW+2:3];

   assign tile_addr = AW'(cur_buf) * BUF_SZ + AW'({pix_cnt_q[7:3], cur_line[2:0]});
   assign rd_addr   = AW'(rd_buf_q) * BUF_SZ + AW'(rd_ptr_q[8:1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q      <= 1'b0;
         pix_cnt_q <= '0;
         cur_line  <= '0;
         p0_q      <= '0;
         p1_q      <= '0;
         row_done  <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         vs_q     <= lcd_vs;
         row_done <= 1'b0;
         // Tile data is latched here so back-to-back pixels cannot disturb the pending write
         wr_en_q  <= tile_done && !vs_rise;
         if (tile_done) begin
            wr_addr_q <= tile_addr;
            wr_data_q <= {p1_nxt, p0_nxt};
         end
         if (vs_rise) begin
            pix_cnt_q <= '0;
            cur_line  <= '0;
            p0_q      <= '0;
            p1_q      <= '0;
         end else if (line_end) begin
            pix_cnt_q <= '0;
            cur_line  <= cur_line + 8'd1;
            row_done  <= (cur_line[2:0] == 3'd7);
         end else if (capture) begin
            p0_q      <= p0_nxt[6:0];
            p1_q      <= p1_nxt[6:0];
            pix_cnt_q <= pix_cnt_q + 8'd1;
         end
      end
   end

   // Buffer RAM is intentionally not reset; read-during-write returns the old word
   always_ff @(posedge clk) begin
      if (wr_en_q) begin
         mem[wr_addr_q] <= wr_data_q;
      end
      mem_q <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_buf_q <= '0;
         rd_ptr_q <= '0;
         hi_q     <= 1'b0;
         rd_data  <= 8'h00;
      end else begin
         if (rd_sel_wr) begin
            rd_buf_q <= rd_sel;
            rd_ptr_q <= '0;
         end else if (rd_strobe) begin
            rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? 9'd0 : rd_ptr_q + 9'd1;
         end
         hi_q    <= rd_ptr_q[0];
         rd_data <= hi_q ? mem_q[15:8] : mem_q[7:0];
      end
   end

endmodule
